// File: rtl/ov7670_sccb_sender.sv
// rtl/ov7670_sccb_sender.sv - SCCB write master that streams the OV7670 register table to the camera
// Frames are ID/REG/VALUE with released ACK slots; a restart never truncates a frame on the bus.
module ov7670_sccb_sender #(
  parameter logic [7:0] DEV_ID      = 8'h42,
  parameter int         QUARTER_CYC = 125,
  parameter int         POWERUP_CYC = 50000,
  parameter int         SOFTRST_CYC = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        restart,
  input  logic [15:0] command,
  input  logic        finished,
  output logic        rom_resend,
  output logic        rom_advance,
  output logic        busy,
  output logic        config_done,
  output logic        sioc,
  output logic        siod_o,
  output logic        siod_oe
);
  localparam int WAIT_MAX = (POWERUP_CYC > SOFTRST_CYC) ? POWERUP_CYC : SOFTRST_CYC;
  localparam int WW = $clog2(WAIT_MAX + 1);
  localparam int QW = (QUARTER_CYC > 1) ? $clog2(QUARTER_CYC) : 1;
  localparam logic [WW-1:0] PWR_LAST  = WW'(POWERUP_CYC - 1);
  localparam logic [WW-1:0] SRST_LAST = WW'(SOFTRST_CYC - 1);
  localparam logic [QW-1:0] Q_LAST    = QW'(QUARTER_CYC - 1);

  typedef enum logic [2:0] {
    S_PWR_WAIT, S_FETCH, S_START, S_BITS, S_STOP, S_GAP, S_SRST_WAIT, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [1:0]    phase_q, phase_d;
  logic [4:0]    bit_q, bit_d;
  logic [26:0]   shift_q, shift_d;
  logic          is_srst_q, is_srst_d;
  logic          pend_q, pend_d;
  logic          resend_q, resend_d;
  logic          advance_q, advance_d;
  logic          sioc_q, sioc_d;
  logic          siod_q, siod_d;
  logic          oe_q, oe_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          abort, step, to_pwr;

  // Bits 9/18/27 of the frame are the camera's ACK / don't-care slots
  function automatic logic is_ack(input logic [4:0] b);
    return (b == 5'd8) || (b == 5'd17) || (b == 5'd26);
  endfunction

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    qcnt_d    = qcnt_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    is_srst_d = is_srst_q;
    resend_d  = resend_q;
    advance_d = 1'b0;
    sioc_d    = sioc_q;
    siod_d    = siod_q;
    oe_d      = oe_q;
    pend_d    = pend_q | restart;
    abort     = pend_q | restart;
    step      = (qcnt_q == Q_LAST);
    to_pwr    = 1'b0;
    if (state_q inside {S_START, S_BITS, S_STOP, S_GAP})
      qcnt_d = step ? '0 : qcnt_q + 1'b1;

    case (state_q)
      S_PWR_WAIT: begin
        resend_d = 1'b1;
        if (abort) to_pwr = 1'b1;
        else if (wait_q == PWR_LAST) begin
          resend_d = 1'b0;
          wait_d   = '0;
          state_d  = S_FETCH;
        end else wait_d = wait_q + 1'b1;
      end
      S_FETCH: begin
        // command/finished lag the table address by two registered stages
        if (abort) to_pwr = 1'b1;
        else if (wait_q == WW'(1)) begin
          wait_d = '0;
          if (finished) state_d = S_DONE;
          else begin
            shift_d   = {DEV_ID, 1'b1, command[15:8], 1'b1, command[7:0], 1'b1};
            is_srst_d = (command == 16'h1280);
            state_d   = S_START;
            qcnt_d    = '0;
            phase_d   = 2'd0;
            sioc_d    = 1'b1;
            siod_d    = 1'b1;
            oe_d      = 1'b1;
          end
        end else wait_d = wait_q + 1'b1;
      end
      S_START: begin
        if (step) begin
          phase_d = phase_q + 1'b1;
          case (phase_q)
            2'd0: siod_d = 1'b0;
            2'd1: sioc_d = 1'b0;
            default: begin
              state_d = S_BITS;
              phase_d = 2'd0;
              bit_d   = 5'd0;
              siod_d  = shift_q[26];
              oe_d    = 1'b1;
            end
          endcase
        end
      end
      S_BITS: begin
        if (step) begin
          phase_d = phase_q + 1'b1;
          if (phase_q == 2'd1) sioc_d = 1'b1;
          else if (phase_q == 2'd3) begin
            phase_d = 2'd0;
            sioc_d  = 1'b0;
            if (bit_q == 5'd26) begin
              state_d = S_STOP;
              siod_d  = 1'b0;
              oe_d    = 1'b1;
            end else begin
              bit_d   = bit_q + 5'd1;
              shift_d = {shift_q[25:0], 1'b0};
              siod_d  = shift_q[25];
              oe_d    = !is_ack(bit_q + 5'd1);
            end
          end
        end
      end
      S_STOP: begin
        if (step) begin
          phase_d = phase_q + 1'b1;
          if (phase_q == 2'd0) sioc_d = 1'b1;
          else if (phase_q == 2'd1) siod_d = 1'b1;
          else if (phase_q == 2'd3) begin
            if (abort) to_pwr = 1'b1;
            else begin
              state_d   = S_GAP;
              phase_d   = 2'd0;
              advance_d = 1'b1;
            end
          end
        end
      end
      S_GAP: begin
        if (abort) to_pwr = 1'b1;
        else if (step) begin
          phase_d = phase_q + 1'b1;
          if (phase_q == 2'd3) begin
            wait_d  = '0;
            state_d = is_srst_q ? S_SRST_WAIT : S_FETCH;
          end
        end
      end
      S_SRST_WAIT: begin
        if (abort) to_pwr = 1'b1;
        else if (wait_q == SRST_LAST) begin
          wait_d  = '0;
          state_d = S_FETCH;
        end else wait_d = wait_q + 1'b1;
      end
      default: begin
        if (abort) to_pwr = 1'b1;
      end
    endcase

    if (to_pwr) begin
      state_d  = S_PWR_WAIT;
      wait_d   = '0;
      qcnt_d   = '0;
      phase_d  = 2'd0;
      resend_d = 1'b1;
      pend_d   = 1'b0;
      sioc_d   = 1'b1;
      siod_d   = 1'b1;
      oe_d     = 1'b1;
    end
    busy_d = (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_PWR_WAIT;
      wait_q    <= '0;
      qcnt_q    <= '0;
      phase_q   <= 2'd0;
      bit_q     <= 5'd0;
      shift_q   <= '0;
      is_srst_q <= 1'b0;
      pend_q    <= 1'b0;
      resend_q  <= 1'b1;
      advance_q <= 1'b0;
      sioc_q    <= 1'b1;
      siod_q    <= 1'b1;
      oe_q      <= 1'b1;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      qcnt_q    <= qcnt_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      is_srst_q <= is_srst_d;
      pend_q    <= pend_d;
      resend_q  <= resend_d;
      advance_q <= advance_d;
      sioc_q    <= sioc_d;
      siod_q    <= siod_d;
      oe_q      <= oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign rom_resend  = resend_q;
  assign rom_advance = advance_q;
  assign busy        = busy_q;
  assign config_done = done_q;
  assign sioc        = sioc_q;
  assign siod_o      = siod_q;
  assign siod_oe     = oe_q;
endmodule

// File: tb/tb_ov7670_sccb_sender.sv
// tb/tb_ov7670_sccb_sender.sv - randomized scoreboard bench for the SCCB table sender
// A behavioural register table feeds the DUT; an SCCB line decoder pops expected writes.
module tb_ov7670_sccb_sender;
  localparam int QC = 4;
  localparam int PC = 16;
  localparam int SC = 32;
  localparam logic [7:0] DEV = 8'h42;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        restart = 1'b0;
  logic [15:0] command = 16'h0000;
  logic        finished;
  logic        rom_resend, rom_advance, busy, config_done, sioc, siod_o, siod_oe;

  ov7670_sccb_sender #(
    .DEV_ID(DEV), .QUARTER_CYC(QC), .POWERUP_CYC(PC), .SOFTRST_CYC(SC)
  ) dut (
    .clk(clk), .rst(rst), .restart(restart), .command(command), .finished(finished),
    .rom_resend(rom_resend), .rom_advance(rom_advance), .busy(busy),
    .config_done(config_done), .sioc(sioc), .siod_o(siod_o), .siod_oe(siod_oe)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Registered command table: address reacts to resend/advance, data one cycle later
  logic [15:0] tbl [0:15];
  logic [3:0]  addr = 4'd0;
  always @(posedge clk) begin
    if (rom_resend) addr <= 4'd0;
    else if (rom_advance) addr <= addr + 4'd1;
    command <= tbl[addr];
  end
  assign finished = (command == 16'hFFFF);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [23:0] exp_q [$];
  int          adv_cnt = 0;
  int          frames = 0;
  int          nbits = 0;
  int          sioc_falls = 0;
  int          last_rise = 0;
  int          stop_cyc = 0;
  logic        prev_adv = 1'b0;
  logic        in_frame = 1'b0;
  logic        last_srst = 1'b0;
  logic        prev_sioc = 1'b1;
  logic        prev_sd = 1'b1;
  logic [26:0] fbits = '0;

  always @(negedge clk) begin : monitor
    logic        sd;
    logic [23:0] got;
    sd = siod_oe ? siod_o : 1'b1;
    if (rst) begin
      in_frame  = 1'b0;
      last_srst = 1'b0;
      prev_adv  = 1'b0;
    end else begin
      if (rom_advance) begin
        adv_cnt++;
        chk("advance_single_cycle", prev_adv, 1'b0);
      end
      prev_adv = rom_advance;
      if (prev_sioc && !sioc) sioc_falls++;
      if (sioc && prev_sioc && prev_sd && !sd) begin
        chk("start_outside_frame", in_frame, 1'b0);
        if (last_srst) chk("softreset_gap", ((cyc - stop_cyc) >= SC) ? 1 : 0, 1);
        last_srst = 1'b0;
        in_frame  = 1'b1;
        nbits     = 0;
        fbits     = '0;
      end else if (sioc && prev_sioc && !prev_sd && sd && in_frame) begin
        chk("frame_bit_count", nbits, 27);
        got = {fbits[26:19], fbits[17:10], fbits[8:1]};
        if (exp_q.size() == 0) begin
          n_total++;
          n_bad++;
          $display("FAIL unexpected_frame: got %0h expected none", got);
        end else chk("frame_data", got, exp_q.pop_front());
        frames++;
        in_frame  = 1'b0;
        stop_cyc  = cyc;
        last_srst = (got[15:0] == 16'h1280);
      end else if (sioc && !prev_sioc && in_frame && nbits < 27) begin
        if (nbits > 0) chk("sioc_period", cyc - last_rise, 4 * QC);
        last_rise = cyc;
        chk("ack_slot_release", siod_oe, (nbits == 8 || nbits == 17 || nbits == 26) ? 0 : 1);
        fbits = {fbits[25:0], sd};
        nbits++;
      end
    end
    prev_sioc = sioc;
    prev_sd   = sd;
  end

  function automatic int table_len();
    int n = 0;
    while (n < 16 && tbl[n] != 16'hFFFF) n++;
    return n;
  endfunction

  task automatic push_table();
    for (int i = 0; i < table_len(); i++) exp_q.push_back({DEV, tbl[i]});
  endtask

  task automatic reset_and_release();
    rst = 1'b1;
    restart = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sioc", sioc, 1'b1);
    chk("rst_siod", siod_o, 1'b1);
    chk("rst_oe", siod_oe, 1'b1);
    chk("rst_resend", rom_resend, 1'b1);
    chk("rst_advance", rom_advance, 1'b0);
    chk("rst_done", config_done, 1'b0);
    chk("rst_busy", busy, 1'b1);
    rst = 1'b0;
  endtask

  task automatic check_resend();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rom_resend && n < 10 * PC);
    chk("resend_length", n, PC);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!config_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("config_done_reached", config_done, 1'b1);
  endtask

  task automatic run_table();
    int a0;
    exp_q.delete();
    push_table();
    reset_and_release();
    a0 = adv_cnt;
    check_resend();
    wait_done(200 + 600 * (table_len() + 1));
    chk("busy_in_done", busy, 1'b0);
    chk("advance_count", adv_cnt - a0, table_len());
    chk("scoreboard_drained", exp_q.size(), 0);
    repeat (20) @(negedge clk);
    chk("done_holds", config_done, 1'b1);
    chk("idle_sioc", sioc, 1'b1);
    chk("idle_siod", siod_o, 1'b1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n, a0, a1, f0, s0, fall_n;
    for (int i = 0; i < 16; i++) tbl[i] = 16'hFFFF;

    // soft-reset entry followed by a normal write
    tbl[0] = 16'h1280; tbl[1] = 16'h1200; tbl[2] = 16'hFFFF;
    run_table();

    // ACK slots and bit timing on a single write
    tbl[0] = 16'h3A04; tbl[1] = 16'hFFFF;
    run_table();

    // restart in the middle of the second frame
    tbl[0] = 16'h1280; tbl[1] = 16'h1200; tbl[2] = 16'h3A04; tbl[3] = 16'hFFFF;
    exp_q.delete();
    exp_q.push_back({DEV, 16'h1280});
    exp_q.push_back({DEV, 16'h1200});
    push_table();
    reset_and_release();
    a0 = adv_cnt;
    f0 = frames;
    check_resend();
    n = 0;
    while (!(frames == f0 + 1 && in_frame && nbits >= 5) && n < 3000) begin
      @(negedge clk); #1;
      n++;
    end
    chk("reached_frame2_bits", in_frame, 1'b1);
    restart = 1'b1;
    @(negedge clk); #1;
    restart = 1'b0;
    a1 = adv_cnt;
    n = 0;
    while (!rom_resend && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("resend_after_restart", rom_resend, 1'b1);
    chk("frame2_completed", frames - f0, 2);
    chk("no_advance_on_restart", adv_cnt - a1, 0);
    wait_done(3000);
    chk("restart_advance_total", adv_cnt - a0, 4);
    chk("restart_scoreboard", exp_q.size(), 0);

    // empty table: no bus activity, done two cycles after the power-up wait
    tbl[0] = 16'hFFFF;
    exp_q.delete();
    reset_and_release();
    s0 = sioc_falls;
    n = 0;
    fall_n = 0;
    while (!config_done && n < 200) begin
      @(negedge clk);
      n++;
      if (!rom_resend && fall_n == 0) fall_n = n;
    end
    chk("empty_resend_length", fall_n, PC);
    chk("empty_done_latency", n, PC + 2);
    chk("empty_no_sioc", sioc_falls - s0, 0);

    // asynchronous reset in the middle of a frame, then a full rerun
    tbl[0] = 16'h3A04; tbl[1] = 16'h1200; tbl[2] = 16'hFFFF;
    exp_q.delete();
    push_table();
    reset_and_release();
    check_resend();
    n = 0;
    while (!(in_frame && nbits >= 10) && n < 1000) begin
      @(negedge clk); #1;
      n++;
    end
    chk("reached_mid_frame", in_frame, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_sioc", sioc, 1'b1);
    chk("async_rst_siod", siod_o, 1'b1);
    chk("async_rst_oe", siod_oe, 1'b1);
    chk("async_rst_done", config_done, 1'b0);
    run_table();

    // random tables, occasionally led by the soft-reset entry
    for (int k = 0; k < 3; k++) begin
      int len;
      len = $urandom_range(1, 4);
      for (int i = 0; i < 16; i++) tbl[i] = 16'hFFFF;
      for (int i = 0; i < len; i++)
        tbl[i] = {8'($urandom_range(0, 254)), 8'($urandom_range(0, 255))};
      if ($urandom_range(0, 2) == 0) tbl[0] = 16'h1280;
      run_table();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
